// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and width for the up/down counter and its command sequencer
package count_pkg;

  localparam int unsigned COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIN  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/count_cmd_seq.sv
// rtl/count_cmd_seq.sv - command sequencer driving load/up/down of the up/down counter
module count_cmd_seq
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             high,
  input  logic             low,
  output logic             load,
  output logic             up,
  output logic             down,
  output logic [WIDTH-1:0] ld_value,
  output logic             done,
  output logic             sat_err
);

  seq_state_t       state_q, state_d;
  cmd_op_t          op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    load      = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    done      = 1'b0;
    sat_err   = 1'b0;
    // Flags already reflect the previous pulse, so this check is never one step stale.
    at_limit  = ((op_q == OP_UP) && high) || ((op_q == OP_DOWN) && low);

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op_t'(cmd_op);
          arg_d = cmd_arg;
          case (cmd_op_t'(cmd_op))
            OP_NOP:  state_d = ST_FIN;
            OP_LOAD: state_d = ST_LOAD;
            default: begin
              rem_d   = cmd_arg;
              state_d = (cmd_arg == '0) ? ST_FIN : ST_RUN;
            end
          endcase
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_FIN;
      end
      ST_RUN: begin
        if (at_limit) begin
          sat_err = 1'b1;
          state_d = ST_FIN;
        end else begin
          up    = (op_q == OP_UP);
          down  = (op_q == OP_DOWN);
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ld_value = arg_q;

endmodule

// File: tb/tb_count_cmd_seq.sv
// tb/tb_count_cmd_seq.sv - self-checking bench for count_cmd_seq with a 4-bit counter model
module tb_count_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       high, low;
  logic       load, up, down, done, sat_err;
  logic [3:0] ld_value;

  logic [3:0] cnt_q;
  int         cnt_m = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  count_cmd_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .high(high), .low(low),
    .load(load), .up(up), .down(down),
    .ld_value(ld_value), .done(done), .sat_err(sat_err)
  );

  // Counter the sequencer drives; its flags close the loop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= 4'd0;
    else if (load) cnt_q <= ld_value;
    else if (up)   cnt_q <= cnt_q + 4'd1;
    else if (down) cnt_q <= cnt_q - 4'd1;
  end
  assign high = (cnt_q == 4'd15);
  assign low  = (cnt_q == 4'd0);

  // {ready, load, up, down, done, sat_err}
  function automatic logic [5:0] outv();
    return {cmd_ready, load, up, down, done, sat_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg);
    logic [5:0] exp_v[$];
    int         room, k;
    exp_v = {};
    k = 0;
    case (op)
      2'd0: exp_v.push_back(6'b000010);
      2'd1: begin
        exp_v.push_back(6'b010000);
        exp_v.push_back(6'b000010);
      end
      default: begin
        room = (op == 2'd2) ? (15 - cnt_m) : cnt_m;
        k = (int'(arg) < room) ? int'(arg) : room;
        for (int i = 0; i < k; i++) exp_v.push_back((op == 2'd2) ? 6'b001000 : 6'b000100);
        if (k < int'(arg)) exp_v.push_back(6'b000001);
        exp_v.push_back(6'b000010);
      end
    endcase
    exp_v.push_back(6'b100000);
    if (op == 2'd1) cnt_m = arg;
    else if (op == 2'd2) cnt_m = cnt_m + k;
    else if (op == 2'd3) cnt_m = cnt_m - k;

    @(negedge clk);
    chk($sformatf("ready_op%0d_arg%0d", op, arg), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < exp_v.size(); i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("op%0d_arg%0d_c%0d", op, arg, i + 1), outv(), exp_v[i]);
      if (exp_v[i][4]) chk($sformatf("ld_value_c%0d", i + 1), ld_value, arg);
    end
    chk($sformatf("count_op%0d_arg%0d", op, arg), cnt_q, cnt_m);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", outv(), 6'b100000);
    chk("reset_ld_value", ld_value, 0);
    rst = 1'b1;

    run_cmd(2'd1, 4'd9);
    run_cmd(2'd1, 4'd2);
    run_cmd(2'd2, 4'd3);
    run_cmd(2'd1, 4'd13);
    run_cmd(2'd2, 4'd5);
    run_cmd(2'd1, 4'd1);
    run_cmd(2'd3, 4'd4);
    run_cmd(2'd2, 4'd0);
    run_cmd(2'd0, 4'd0);

    // Valid held high across FIN: second NOP must wait for ready.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 4'd0;
    @(negedge clk); chk("hold_c1", outv(), 6'b000010);
    @(negedge clk); chk("hold_c2", outv(), 6'b100000);
    @(negedge clk); chk("hold_c3", outv(), 6'b000010);
    cmd_valid = 1'b0;
    @(negedge clk); chk("hold_c4", outv(), 6'b100000);

    // Reset in the middle of UP 6.
    run_cmd(2'd1, 4'd3);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 4'd6;
    @(negedge clk); cmd_valid = 1'b0;
    chk("midrst_c1", outv(), 6'b001000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", outv(), 6'b100000);
    chk("midrst_ld_value", ld_value, 0);
    chk("midrst_count", cnt_q, 0);
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_idle_%0d", i), outv(), 6'b100000);
    end
    run_cmd(2'd1, 4'd7);

    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
